result_drain: RTL

Parametrised, synthesizable drain engine for the Bellman-Ford output memory. It replaces the bench-side dump loop. On a rising edge of `finish` it scans the output memory through its read port and streams every distance entry over a valid/ready interface, tagging unreachable entries. On a rising edge of `neg_cycle` it emits a single status beat instead of a scan. It sits between the `bellmanford` core / output SRAM read port and any downstream consumer: host bridge, FIFO, or bench monitor.

---
 rtl/result_drain.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/result_drain.sv
// Drains the Bellman-Ford output memory over a valid/ready stream once the core
// finishes, ending with a trailer beat; a negative cycle yields only the trailer.
module result_drain #(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 13,
   parameter int                DEPTH    = 8192,
   parameter logic [DATA_W-1:0] INF_VAL  = {DATA_W{1'b1}},
   parameter bit                SKIP_INF = 1'b0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              finish,
   input  logic              neg_cycle,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_index,
   output logic              out_inf,
   output logic              out_status,
   output logic              out_neg,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   reach_count
);
   typedef enum logic [2:0] {IDLE, SCAN, DRAIN, TRAIL, DONE} state_t;

   // The pointer is one bit wider than the address so DEPTH = 2^ADDR_W never wraps.
   localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};

   state_t            state_reg, state_next;
   logic [ADDR_W:0]   ptr_reg;
   logic              finish_q, neg_q, armed_reg;
   logic              fin_rise, neg_rise, slot_free, is_inf, accept;
   logic [DATA_W-1:0] trailer_count;

   generate
      if (DATA_W <= ADDR_W + 1) begin : g_cnt_trunc
         assign trailer_count = reach_count[DATA_W-1:0];
      end else begin : g_cnt_ext
         assign trailer_count = {{(DATA_W-ADDR_W-1){1'b0}}, reach_count};
      end
   endgenerate

   // armed_reg masks the first cycle after reset so a level still high is not an edge.
   assign fin_rise  = finish & ~finish_q & armed_reg;
   assign neg_rise  = neg_cycle & ~neg_q & armed_reg;
   assign slot_free = !out_valid || out_ready;
   assign accept    = out_valid && out_ready;
   assign is_inf    = (rd_data == INF_VAL);
   assign rd_addr   = (state_reg == SCAN) ? ptr_reg[ADDR_W-1:0] : '0;

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE: begin
            if (neg_rise)      state_next = TRAIL;
            else if (fin_rise) state_next = SCAN;
         end
         SCAN:    if (slot_free && ptr_reg == LAST_PTR) state_next = DRAIN;
         DRAIN:   if (slot_free) state_next = TRAIL;
         TRAIL:   if (accept) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         ptr_reg     <= '0;
         finish_q    <= 1'b0;
         neg_q       <= 1'b0;
         armed_reg   <= 1'b0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_index   <= '0;
         out_inf     <= 1'b0;
         out_status  <= 1'b0;
         out_neg     <= 1'b0;
         out_last    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         reach_count <= '0;
      end else begin
         state_reg <= state_next;
         finish_q  <= finish;
         neg_q     <= neg_cycle;
         armed_reg <= 1'b1;
         done      <= (state_reg == DONE);
         // busy stays up through the done pulse and drops the cycle after it.
         busy      <= (state_next != IDLE) || (state_reg == DONE);
         case (state_reg)
            IDLE: begin
               if (neg_rise) begin
                  out_valid   <= 1'b1;
                  out_data    <= '0;
                  out_index   <= '0;
                  out_inf     <= 1'b0;
                  out_status  <= 1'b1;
                  out_neg     <= 1'b1;
                  out_last    <= 1'b1;
                  reach_count <= '0;
               end else if (fin_rise) begin
                  ptr_reg     <= '0;
                  reach_count <= '0;
               end
            end
            SCAN: begin
               if (slot_free) begin
                  if (SKIP_INF && is_inf) begin
                     out_valid <= 1'b0;
                  end else begin
                     out_valid <= 1'b1;
                     out_data  <= rd_data;
                     out_index <= ptr_reg[ADDR_W-1:0];
                     out_inf   <= is_inf;
                  end
                  ptr_reg <= ptr_reg + ONE;
                  if (!is_inf) reach_count <= reach_count + ONE;
               end
            end
            DRAIN: begin
               if (slot_free) begin
                  out_valid  <= 1'b1;
                  out_data   <= trailer_count;
                  out_index  <= '0;
                  out_inf    <= 1'b0;
                  out_status <= 1'b1;
                  out_neg    <= 1'b0;
                  out_last   <= 1'b1;
               end
            end
            TRAIL: begin
               if (accept) begin
                  out_valid  <= 1'b0;
                  out_data   <= '0;
                  out_status <= 1'b0;
                  out_neg    <= 1'b0;
                  out_last   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
